// File: rtl/cpu_pkg.sv
// Shared constants and types for the instruction-fetch front end.
// Default widths, reset PC, sequential increment and the fetch FSM state encoding.
package cpu_pkg;

  localparam int          DEF_ADDR_W   = 32;
  localparam int          DEF_INSTR_W  = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'h0000_0004;

  typedef enum logic {
    REQ  = 1'b0,
    WAIT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry valid/ready register slice holding {pc, instr} for decode.
// A flush empties the slot and wins over a simultaneous load or consume.
module fetch_out_buf #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               load,
  input  logic [ADDR_W-1:0]  load_pc,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  logic               valid_r, valid_s;
  logic [ADDR_W-1:0]  pc_r, pc_s;
  logic [INSTR_W-1:0] instr_r, instr_s;

  // Next slot contents: flush, then load, then consume.
  always_comb begin
    valid_s = valid_r;
    pc_s    = pc_r;
    instr_s = instr_r;
    if (flush) begin
      valid_s = 1'b0;
    end else if (load) begin
      valid_s = 1'b1;
      pc_s    = load_pc;
      instr_s = load_instr;
    end else if (valid_r && out_ready) begin
      valid_s = 1'b0;
    end else begin
      valid_s = valid_r;
    end
  end

  // Slot registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      pc_r    <= '0;
      instr_r <= '0;
    end else begin
      valid_r <= valid_s;
      pc_r    <= pc_s;
      instr_r <= instr_s;
    end
  end

  assign out_valid = valid_r;
  assign out_pc    = pc_r;
  assign out_instr = instr_r;

endmodule

// File: rtl/pc_fetch_unit.sv
// Owns the architectural PC, issues single-outstanding instruction fetches and
// hands {pc, instr} to decode; a redirect reloads the PC and squashes wrong-path work.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr
);

  fetch_state_e      state_r, state_s;
  logic [ADDR_W-1:0] pc_r, pc_s;
  logic [ADDR_W-1:0] req_pc_r, req_pc_s;
  logic              kill_r, kill_s;
  logic              accept_s;
  logic              buf_load_s;
  logic              buf_valid_s;
  logic [ADDR_W-1:0] target_s;

  assign target_s       = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign imem_req_valid = rst_n && (state_r == REQ) && !buf_valid_s;
  assign imem_req_addr  = pc_r;
  assign accept_s       = imem_req_valid && imem_req_ready;
  assign if_valid       = buf_valid_s;

  // Fetch FSM: redirect overrides sequential advance and marks in-flight data dead.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    req_pc_s   = req_pc_r;
    kill_s     = kill_r;
    buf_load_s = 1'b0;
    case (state_r)
      REQ: begin
        if (redirect_valid) begin
          pc_s = target_s;
          if (accept_s) begin
            kill_s  = 1'b1;
            state_s = WAIT;
          end else begin
            state_s = REQ;
          end
        end else if (accept_s) begin
          req_pc_s = pc_r;
          pc_s     = pc_r + ADDR_W'(PC_INC);
          state_s  = WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_s = target_s;
          if (imem_rsp_valid) begin
            kill_s  = 1'b0;
            state_s = REQ;
          end else begin
            kill_s  = 1'b1;
            state_s = WAIT;
          end
        end else if (imem_rsp_valid) begin
          buf_load_s = !kill_r;
          kill_s     = 1'b0;
          state_s    = REQ;
        end else begin
          state_s = WAIT;
        end
      end
      default: begin
        state_s = REQ;
        kill_s  = 1'b0;
      end
    endcase
  end

  // FSM and PC registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= REQ;
      pc_r     <= RESET_PC;
      req_pc_r <= '0;
      kill_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      req_pc_r <= req_pc_s;
      kill_r   <= kill_s;
    end
  end

  fetch_out_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_out_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .load       (buf_load_s),
    .load_pc    (req_pc_r),
    .load_instr (imem_rsp_data),
    .out_ready  (if_ready),
    .out_valid  (buf_valid_s),
    .out_pc     (if_pc),
    .out_instr  (if_instr)
  );

endmodule
